// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding, expected-data rule and read latency for the RAM BIST.
package ram_bist_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam int RD_LAT = 1;

    // Wide result; callers size-cast to DATA_WIDTH, which gives the mod 2**DATA_WIDTH wrap.
    function automatic logic [63:0] exp_data(input logic p, input logic [63:0] a);
        return p ? ~(a + 64'd1) : a + 64'd1;
    endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if: RAM-side bus between the BIST controller (master) and dual_port_ram (slave).
interface ram_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic                  port_en_0;
    logic [ADDR_WIDTH-1:0] addr_in_0;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  port_en_1;
    logic [ADDR_WIDTH-1:0] addr_in_1;
    logic [DATA_WIDTH-1:0] data_out_1;

    modport master (
        output wr_en, port_en_0, addr_in_0, data_in, port_en_1, addr_in_1,
        input  data_out_1
    );

    modport slave (
        input  wr_en, port_en_0, addr_in_0, data_in, port_en_1, addr_in_1,
        output data_out_1
    );
endinterface

// File: rtl/ram_bist_checker.sv
// ram_bist_checker: one-deep read pipeline, data compare, error count and first-failure capture.
module ram_bist_checker #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] exp,
    input  logic                  pidx,
    input  logic [DATA_WIDTH-1:0] data_out_1,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  first_fail_pass
);
    logic                  v_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] e_q;
    logic                  p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q             <= 1'b0;
            a_q             <= '0;
            e_q             <= '0;
            p_q             <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_pass <= 1'b0;
        end else begin
            v_q <= valid;
            a_q <= addr;
            e_q <= exp;
            p_q <= pidx;
            if (clear) begin
                err_count       <= '0;
                first_fail_addr <= '0;
                first_fail_pass <= 1'b0;
            end else if (v_q && data_out_1 != e_q) begin
                err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    first_fail_addr <= a_q;
                    first_fail_pass <= p_q;
                end
            end
        end
    end
endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: two-pass march BIST initiator for dual_port_ram (write addr+1, then its complement).
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  first_fail_pass,
    ram_bist_ctrl_if.master       ram
);
    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  pidx;
    logic                  pass_q;
    logic                  last;
    logic [DATA_WIDTH-1:0] exp;

    assign last = &addr;
    assign exp  = DATA_WIDTH'(exp_data(pidx, 64'(addr)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            pidx   <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nx;
            addr   <= (state == WRITE || state == READ) ? addr + 1'b1 : '0;
            pidx   <= (state == IDLE) ? 1'b0 : (state == DRAIN) ? 1'b1 : pidx;
            pass_q <= (state == IDLE && start) ? 1'b0 : (state == DONE) ? (err_count == '0) : pass_q;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? WRITE : IDLE;
            WRITE:   state_nx = last ? READ : WRITE;
            READ:    state_nx = last ? DRAIN : READ;
            DRAIN:   state_nx = pidx ? DONE : WRITE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy          = state != IDLE;
        done          = state == DONE;
        pass          = (state == DONE) ? (err_count == '0) : pass_q;
        ram.wr_en     = state == WRITE;
        ram.port_en_0 = state == WRITE;
        ram.addr_in_0 = (state == WRITE) ? addr : '0;
        ram.data_in   = (state == WRITE) ? exp : '0;
        ram.port_en_1 = state == READ;
        ram.addr_in_1 = (state == READ) ? addr : '0;
    end

    // The read issued in the last READ cycle is compared during DRAIN.
    ram_bist_checker #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_checker (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (state == IDLE && start),
        .valid           (state == READ),
        .addr            (addr),
        .exp             (exp),
        .pidx            (pidx),
        .data_out_1      (ram.data_out_1),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_pass (first_fail_pass)
    );
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: fault-injecting RAM model plus a march reference model checking ram_bist_ctrl.
module tb_ram_bist_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, ffp;
    logic [AW+1:0] err_count;
    logic [AW-1:0] ffa;

    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] and_m [DEPTH];
    logic [DW-1:0] or_m  [DEPTH];

    int vec = 0;
    int bad = 0;
    int wr_q[$];
    int rd_q[$];
    int run_q[$];
    int oop, run, lat, busy_n, done_n;

    always #5 clk = ~clk;

    ram_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (ffa),
        .first_fail_pass (ffp),
        .ram             (bus)
    );

    // RAM with per-address read-side stuck-at masks
    always @(posedge clk) begin
        if (bus.wr_en && bus.port_en_0) mem[bus.addr_in_0] <= bus.data_in;
        if (bus.port_en_1) bus.data_out_1 <= (mem[bus.addr_in_1] & and_m[bus.addr_in_1]) | or_m[bus.addr_in_1];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_faults;
        for (int a = 0; a < DEPTH; a++) begin
            and_m[a] = 8'hFF;
            or_m[a]  = 8'h00;
        end
    endtask

    // Reference: every (pass, address) in march order, expected vs what the faulty RAM returns.
    task automatic model(output int e, output int fa, output int fp);
        e = 0;
        fa = 0;
        fp = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [DW-1:0] x, r;
                x = 8'(a + 1);
                if (p == 1) x = ~x;
                r = (x & and_m[a]) | or_m[a];
                if (r !== x) begin
                    if (e == 0) begin
                        fa = a;
                        fp = p;
                    end
                    e++;
                end
            end
        end
    endtask

    task automatic run_bist(input int pa, input int pb);
        wr_q.delete();
        rd_q.delete();
        run_q.delete();
        oop = 0;
        run = 0;
        lat = 0;
        busy_n = 0;
        done_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            busy_n += int'(busy);
            if (done) begin
                done_n++;
                if (lat == 0) lat = c;
            end
            if (bus.wr_en) begin
                wr_q.push_back(int'(bus.addr_in_0) * 256 + int'(bus.data_in));
                run++;
            end else begin
                if (run > 0) run_q.push_back(run);
                run = 0;
                if (bus.addr_in_0 != 0 || bus.data_in != 0) oop++;
            end
            if (bus.wr_en != bus.port_en_0) oop++;
            if (bus.port_en_1) rd_q.push_back(int'(bus.addr_in_1));
            else if (bus.addr_in_1 != 0) oop++;
            if (bus.port_en_1 && bus.wr_en) oop++;
            start = (c == pa || c == pb);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        vec++;
        if ({busy, done, pass, err_count, ffa, ffp, bus.wr_en, bus.port_en_0, bus.addr_in_0,
             bus.data_in, bus.port_en_1, bus.addr_in_1} !== 33'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d wr_en=%b pe1=%b, want all 0",
                     busy, done, pass, err_count, bus.wr_en, bus.port_en_1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clean;
        int e, fa, fp, bw, rb;
        clear_faults();
        repeat (3) tick();
        run_bist(0, 0);
        model(e, fa, fp);
        vec++;
        if (lat != 67) begin bad++; $display("FAIL clean_latency: got %0d want 67", lat); end
        vec++;
        if (busy_n != 67) begin bad++; $display("FAIL clean_busy_cycles: got %0d want 67", busy_n); end
        vec++;
        if (done_n != 1) begin bad++; $display("FAIL clean_done_pulses: got %0d want 1", done_n); end
        vec++;
        if (pass !== 1'b1 || err_count !== 6'(e) || ffa !== 4'(fa) || ffp !== 1'(fp)) begin
            bad++;
            $display("FAIL clean_result: pass=%b err=%0d ffa=%0d ffp=%b want pass=1 err=%0d ffa=%0d ffp=%0d",
                     pass, err_count, ffa, ffp, e, fa, fp);
        end
        bw = 0;
        if (wr_q.size() != 2 * DEPTH) bw = 1000;
        else for (int i = 0; i < 2 * DEPTH; i++) begin
            int a, d;
            a = i % DEPTH;
            d = (i < DEPTH) ? a + 1 : (~(a + 1)) & 255;
            if (wr_q[i] != a * 256 + d) bw++;
        end
        vec++;
        if (bw != 0) begin bad++; $display("FAIL write_sequence: %0d bad writes of %0d, want 0", bw, wr_q.size()); end
        vec++;
        if (run_q.size() != 2 || run_q[0] != 16 || run_q[1] != 16) begin
            bad++;
            $display("FAIL write_runs: got %0d runs, want two runs of 16", run_q.size());
        end
        rb = 0;
        if (rd_q.size() != 2 * DEPTH) rb = 1000;
        else for (int i = 0; i < 2 * DEPTH; i++) if (rd_q[i] != i % DEPTH) rb++;
        vec++;
        if (rb != 0) begin bad++; $display("FAIL read_sequence: %0d bad reads of %0d, want 0", rb, rd_q.size()); end
        vec++;
        if (oop != 0) begin bad++; $display("FAIL out_of_phase: got %0d violations want 0", oop); end
    endtask

    task automatic test_stuck_bit;
        int e, fa, fp;
        clear_faults();
        or_m[5] = 8'h04;
        run_bist(0, 0);
        model(e, fa, fp);
        vec++;
        if (err_count !== 6'd1 || err_count !== 6'(e)) begin
            bad++;
            $display("FAIL stuck_err_count: got %0d want 1 (model %0d)", err_count, e);
        end
        vec++;
        if (ffa !== 4'(fa) || ffp !== 1'(fp) || pass !== 1'b0) begin
            bad++;
            $display("FAIL stuck_first_fail: ffa=%0d ffp=%b pass=%b want ffa=%0d ffp=%0d pass=0", ffa, ffp, pass, fa, fp);
        end
    endtask

    task automatic test_two_faults;
        int e, fa, fp;
        clear_faults();
        and_m[3] = 8'h00;
        or_m[9]  = 8'hFF;
        run_bist(0, 0);
        model(e, fa, fp);
        vec++;
        if (err_count !== 6'(e) || ffa !== 4'(fa) || ffp !== 1'(fp) || pass !== (e == 0)) begin
            bad++;
            $display("FAIL two_faults: err=%0d ffa=%0d ffp=%b pass=%b want err=%0d ffa=%0d ffp=%0d",
                     err_count, ffa, ffp, pass, e, fa, fp);
        end
    endtask

    task automatic test_random;
        int e, fa, fp;
        for (int it = 0; it < 6; it++) begin
            clear_faults();
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
                int a;
                a = int'($urandom_range(0, DEPTH - 1));
                and_m[a] = 8'($urandom);
                or_m[a]  = 8'($urandom) & ~and_m[a];
            end
            repeat ($urandom_range(0, 4)) tick();
            run_bist(0, 0);
            model(e, fa, fp);
            vec++;
            if (err_count !== 6'(e) || ffa !== 4'(fa) || ffp !== 1'(fp) || pass !== (e == 0) || lat != 67) begin
                bad++;
                $display("FAIL random_%0d: err=%0d ffa=%0d ffp=%b pass=%b lat=%0d want err=%0d ffa=%0d ffp=%0d lat=67",
                         it, err_count, ffa, ffp, pass, lat, e, fa, fp);
            end
        end
    endtask

    task automatic test_abort;
        clear_faults();
        or_m[0] = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        vec++;
        if (bus.port_en_1 !== 1'b1) begin bad++; $display("FAIL abort_pre_read: port_en_1=%b want 1", bus.port_en_1); end
        rst_n = 1'b0;
        tick();
        vec++;
        if ({busy, done, pass, err_count, ffa, ffp, bus.wr_en, bus.port_en_0, bus.addr_in_0,
             bus.data_in, bus.port_en_1, bus.addr_in_1} !== 33'd0) begin
            bad++;
            $display("FAIL abort_outputs: busy=%b err=%0d wr_en=%b pe1=%b addr1=%0d want all 0",
                     busy, err_count, bus.wr_en, bus.port_en_1, bus.addr_in_1);
        end
        rst_n = 1'b1;
        tick();
        vec++;
        if (busy !== 1'b0 || bus.port_en_1 !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b pe1=%b want 0 0", busy, bus.port_en_1);
        end
        clear_faults();
        run_bist(0, 0);
        vec++;
        if (pass !== 1'b1 || err_count !== 6'd0 || lat != 67) begin
            bad++;
            $display("FAIL abort_rerun: pass=%b err=%0d lat=%0d want 1 0 67", pass, err_count, lat);
        end
    endtask

    task automatic test_back_to_back;
        clear_faults();
        run_bist(10, 40);
        vec++;
        if (done_n != 1 || lat != 67 || busy_n != 67) begin
            bad++;
            $display("FAIL start_while_busy: done_pulses=%0d lat=%0d busy=%0d want 1 67 67", done_n, lat, busy_n);
        end
        vec++;
        if (err_count !== 6'd0 || pass !== 1'b1) begin
            bad++;
            $display("FAIL start_while_busy_result: err=%0d pass=%b want 0 1", err_count, pass);
        end
    endtask

    task automatic test_start_held;
        int idle_c, rebusy, fin;
        clear_faults();
        idle_c = 0;
        rebusy = 0;
        fin = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 70; c++) begin
            if (!busy && idle_c == 0) idle_c = c;
            if (c == 69) rebusy = int'(busy);
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 100 && fin == 0; c++) begin
            if (done) fin = 1;
            tick();
        end
        tick();
        vec++;
        if (idle_c != 68 || rebusy != 1) begin
            bad++;
            $display("FAIL start_held_restart: idle_cycle=%0d busy@69=%0d want 68 1", idle_c, rebusy);
        end
        vec++;
        if (fin != 1 || busy !== 1'b0 || pass !== 1'b1) begin
            bad++;
            $display("FAIL start_held_finish: done_seen=%0d busy=%b pass=%b want 1 0 1", fin, busy, pass);
        end
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_clean();
        test_stuck_bit();
        test_two_faults();
        test_random();
        test_abort();
        test_back_to_back();
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator for dual_port_ram. Drives the write port (port 0) and read port (port 1), and checks every read against the expected data.
- Two march passes: pass 0 writes addr+1, pass 1 writes ~(addr+1). Each pass reads all locations back through port 1.
- Sits between test/boot control and the RAM; its RAM-side outputs connect straight to the RAM inputs of the same names.

Parameters:
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  input  1  single clock, rising edge; shared with dual_port_ram.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin test; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  result, valid from done; held until the next start is accepted.
- err_count  output  ADDR_WIDTH+2  mismatches over both passes; cleared on start.
- first_fail_addr  output  ADDR_WIDTH  address of the first mismatch; 0 if none.
- first_fail_pass  output  1  pass index of the first mismatch.
- wr_en  output  1  RAM write enable.
- port_en_0  output  1  RAM port-0 enable.
- addr_in_0  output  ADDR_WIDTH  RAM write address.
- data_in  output  DATA_WIDTH  RAM write data.
- port_en_1  output  1  RAM port-1 enable.
- addr_in_1  output  ADDR_WIDTH  RAM read address.
- data_out_1  input  DATA_WIDTH  RAM read data. One-cycle latency: data is valid the cycle after addr_in_1 is presented with port_en_1=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; internal counters 0. A reset mid-test aborts immediately; the next cycle drives all RAM enables low.
- Expected data: exp(p,a) = (a+1) mod 2**DATA_WIDTH for p=0, and its bitwise complement for p=1.
- IDLE -> WRITE when start=1. In the same edge: clear err_count and first_fail_*, set pass=0, set pass index p=0, set addr=0.
- WRITE (2**ADDR_WIDTH cycles):
  - wr_en=port_en_0=1, addr_in_0=addr, data_in=exp(p,addr).
  - addr increments each cycle; on wrap to 0 go to READ.
- READ (2**ADDR_WIDTH cycles):
  - port_en_1=1, addr_in_1=addr, addr increments.
  - A 1-deep pipeline register holds {valid, addr, exp}.
  - On wrap go to DRAIN.
- Compare: each cycle the pipeline register is valid, compare data_out_1 to the registered exp.
  - On mismatch, increment err_count.
  - If err_count was 0, also capture first_fail_addr and first_fail_pass.
- DRAIN (1 cycle):
  - All RAM enables 0; perform the last compare.
  - Then, if p=0: set p=1, addr=0, go to WRITE. If p=1: go to DONE.
- DONE (1 cycle):
  - done=1; pass=(err_count==0), using the value after the final compare.
  - busy=1 in this cycle, then go to IDLE with busy=0.
- Timing: done is high exactly 67 clocks after the edge that samples start (default params). General form: 2*(2*2**ADDR_WIDTH+1)+1.
- RAM-side signals outside their phase:
  - wr_en/port_en_0 are never high outside WRITE; port_en_1 is never high outside READ.
  - addr/data outputs outside their phase hold 0.
- start while busy is ignored, with no restart. start held high through DONE restarts a test on the first IDLE cycle.
- Widths: err_count maximum is 2*2**ADDR_WIDTH, so there is no saturation. Address counter wraps modulo depth.

Decomposition:
- Package ram_bist_pkg holds:
  - the state enum {IDLE, WRITE, READ, DRAIN, DONE};
  - the exp_data(pass, addr) function;
  - the latency constant RD_LAT=1.
- One sub-module, ram_bist_checker: pipeline register, compare, err_count, first_fail capture. Has clear and valid inputs.

Test Plan:
- Good RAM (dual_port_ram instance), start pulse at cycle 3 -> done pulse 67 cycles later; pass=1, err_count=0, busy high for 67 cycles.
- Write-side check: monitor port 0 in pass 0 -> addresses 0..15 carry data 1..16; in pass 1 they carry 0xFE down to 0xEF; wr_en high for 16 consecutive cycles per pass.
- Fault injection: bench RAM model with bit 2 stuck-at-1 at address 5 -> pass 0 reads 0x06 vs expected 0x06 (no error); pass 1 reads 0xFD vs expected 0xF9 (error). Result: err_count=1, first_fail_addr=5, first_fail_pass=1, pass=0.
- Two faults: address 3 returns 0x00 in both passes, address 9 returns 0xFF in both passes -> err_count=4, first_fail_addr=3, first_fail_pass=0.
- Abort: rst_n low for one cycle at cycle 20 of a test -> next cycle all outputs 0, state IDLE. A subsequent start runs a full clean test to pass=1.
- Start while busy: pulse start at cycle 10 and 40 of a test -> ignored; a single done pulse at 67; err_count is unaffected.
